// File: rtl/data_mem_master_pkg.sv
// data_mem_master_pkg: FSM states, size codes and size-to-byte-count helper
package data_mem_master_pkg;

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_STROBE, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // size codes 2 and 3 both mean a full word
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        return size >= SZ_WORD ? 3'd4 : size == SZ_HALF ? 3'd2 : 3'd1;
    endfunction

endpackage

// File: rtl/data_mem_master.sv
// data_mem_master: splits CPU word/half/byte loads and stores into byte accesses
// Ports: clk/rst (sync, active high); req/we/size/addr/wdata request from the
// datapath; rdata/busy/done response; memWrite/memAddress/memDataOut/memDataIn
// drive the byte-wide memory. All outputs are registered.
module data_mem_master
    import data_mem_master_pkg::*;
#(
    parameter int dataWidth    = 8,
    parameter int addressWidth = 32,
    parameter int wordBytes    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req,
    input  logic                           we,
    input  logic [1:0]                     size,
    input  logic [addressWidth-1:0]        addr,
    input  logic [dataWidth*wordBytes-1:0] wdata,
    output logic [dataWidth*wordBytes-1:0] rdata,
    output logic                           busy,
    output logic                           done,
    output logic                           memWrite,
    output logic [addressWidth-1:0]        memAddress,
    output logic [dataWidth-1:0]           memDataOut,
    input  logic [dataWidth-1:0]           memDataIn
);

    state_t                         state, state_nx;
    logic [1:0]                     idx, idx_nx;
    logic [1:0]                     size_q;
    logic [addressWidth-1:0]        addr_q, addr_base, mem_address_nx;
    logic [dataWidth*wordBytes-1:0] wdata_q, wdata_base;
    logic [dataWidth*wordBytes-1:0] rbuf, rbuf_nx, rdata_nx;
    logic [dataWidth-1:0]           mem_data_out_nx;
    logic                           last;

    assign last = idx == 2'(byte_count(size_q) - 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            size_q     <= SZ_BYTE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rbuf       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            memWrite   <= 1'b0;
            memAddress <= '0;
            memDataOut <= '0;
            rdata      <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (state == IDLE && req) begin
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            rbuf       <= rbuf_nx;
            busy       <= state_nx != IDLE;
            done       <= state_nx == DONE;
            memWrite   <= state_nx == WR_STROBE;
            memAddress <= mem_address_nx;
            memDataOut <= mem_data_out_nx;
            rdata      <= rdata_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                state_nx = req ? (we ? WR_SETUP : RD) : IDLE;
                idx_nx   = '0;
            end
            RD: begin
                state_nx = last ? DONE : RD;
                idx_nx   = last ? idx : idx + 2'd1;
            end
            WR_SETUP: state_nx = WR_STROBE;
            WR_STROBE: begin
                state_nx = last ? DONE : WR_SETUP;
                idx_nx   = last ? idx : idx + 2'd1;
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    // Outputs are precomputed from the next state so they appear registered
    // in the same cycle the FSM enters that state. On acceptance the request
    // fields are not latched yet, so the live inputs are used as the base.
    always_comb begin
        addr_base       = (state == IDLE) ? addr : addr_q;
        wdata_base      = (state == IDLE) ? wdata : wdata_q;
        mem_address_nx  = (state_nx == RD || state_nx == WR_SETUP) ? addr_base + addressWidth'(idx_nx) : memAddress;
        mem_data_out_nx = (state_nx == WR_SETUP) ? wdata_base[idx_nx*dataWidth +: dataWidth] : memDataOut;
        rbuf_nx         = (state == IDLE) ? '0 : rbuf;
        if (state == RD)
            rbuf_nx[idx*dataWidth +: dataWidth] = memDataIn;
        rdata_nx        = (state == RD && state_nx == DONE) ? rbuf_nx : rdata;
    end

endmodule

// File: tb/tb_data_mem_master.sv
// tb_data_mem_master: scoreboard bench for data_mem_master with a byte memory model
module tb_data_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy, done, memWrite;
    logic [31:0] memAddress;
    logic [7:0]  memDataOut, memDataIn;

    data_mem_master dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .memWrite(memWrite), .memAddress(memAddress), .memDataOut(memDataOut),
        .memDataIn(memDataIn)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [256];
    logic       poke = 1'b0;
    logic [7:0] poke_a = '0, poke_d = '0;
    always @(posedge clk)
        if (poke) mem[poke_a] <= poke_d;
        else if (memWrite) mem[memAddress[7:0]] <= memDataOut;
    assign memDataIn = mem[memAddress[7:0]];

    logic [31:0] addr_log [$];
    int          pulses = 0, viol = 0;
    logic        pw = 1'b0;
    logic [31:0] pa = '0;
    logic [7:0]  pd = '0;
    always @(negedge clk) begin
        if (busy && !done) addr_log.push_back(memAddress);
        if (memWrite) begin
            if (pw || memAddress != pa || memDataOut != pd) viol++;
            if (!pw) pulses++;
        end
        pw = memWrite;
        pa = memAddress;
        pd = memDataOut;
    end

    typedef struct {
        int          id;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t exp_q [$];

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("done_cycle[op%0d]", e.id), cyc, e.cyc);
                    chk($sformatf("rdata[op%0d]", e.id), rdata, e.rdata);
                end
            end
        end
    endtask

    task automatic do_poke(input logic [7:0] a, input logic [7:0] d);
        poke_a = a;
        poke_d = d;
        poke = 1'b1;
        @(posedge clk);
        #1 poke = 1'b0;
    endtask

    task automatic wait_done(input int id);
        int k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout[op%0d]: got no done in 40 cycles, required done", id);
        end
        @(posedge clk);
        #1;
    endtask

    // called at #1 after an edge, with the DUT in IDLE for the coming edge
    task automatic op(input int id, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input int lat);
        req = 1'b1;
        we = w;
        size = sz;
        addr = a;
        wdata = d;
        exp_q.push_back('{id, er, cyc + lat});
        @(posedge clk);
        #1 req = 1'b0;
        wait_done(id);
    endtask

    function automatic logic [31:0] mw(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    initial begin
        int s, p;
        logic [31:0] wrap_exp [4];
        wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_memWrite", {31'd0, memWrite}, 32'd0);
        chk("reset_memAddress", memAddress, 32'd0);
        chk("reset_memDataOut", {24'd0, memDataOut}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst = 1'b0;

        do_poke(8'h10, 8'h11);
        do_poke(8'h11, 8'h22);
        do_poke(8'h12, 8'h33);
        do_poke(8'h13, 8'h44);

        s = addr_log.size();
        p = pulses;
        op(1, 1'b0, 2'd2, 32'h10, 32'h0, 32'h4433_2211, 5);
        chk("load_word_pulses", pulses - p, 32'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("load_word_addr%0d", i), addr_log[s + i], 32'h10 + i);

        p = pulses;
        op(2, 1'b1, 2'd2, 32'h20, 32'hDEAD_BEEF, 32'h4433_2211, 9);
        chk("store_word_pulses", pulses - p, 32'd4);
        chk("store_word_mem", mw(8'h20), 32'hDEAD_BEEF);

        op(3, 1'b0, 2'd1, 32'h21, 32'h0, 32'h0000_ADBE, 3);

        p = pulses;
        op(4, 1'b1, 2'd0, 32'h22, 32'hFFFF_FF5A, 32'h0000_ADBE, 3);
        chk("store_byte_pulses", pulses - p, 32'd1);
        chk("store_byte_mem", mw(8'h20), 32'hDE5A_BEEF);

        op(5, 1'b0, 2'd0, 32'h22, 32'h0, 32'h0000_005A, 2);

        do_poke(8'hFE, 8'h01);
        do_poke(8'hFF, 8'h02);
        do_poke(8'h00, 8'h03);
        do_poke(8'h01, 8'h04);
        s = addr_log.size();
        op(6, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0, 32'h0403_0201, 5);
        for (int i = 0; i < 4; i++)
            chk($sformatf("wrap_addr%0d", i), addr_log[s + i], wrap_exp[i]);

        s = addr_log.size();
        req = 1'b1;
        we = 1'b0;
        size = 2'd2;
        addr = 32'h10;
        exp_q.push_back('{7, 32'h4433_2211, cyc + 5});
        exp_q.push_back('{8, 32'h4433_2211, cyc + 11});
        repeat (7) @(posedge clk);
        #1 req = 1'b0;
        wait_done(8);
        chk("interlock_accesses", addr_log.size() - s, 32'd8);

        do_poke(8'h30, 8'hAA);
        do_poke(8'h31, 8'hAA);
        do_poke(8'h32, 8'hAA);
        do_poke(8'h33, 8'hAA);
        req = 1'b1;
        we = 1'b1;
        size = 2'd2;
        addr = 32'h30;
        wdata = 32'h1122_3344;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("third_strobe_memWrite", {31'd0, memWrite}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_memWrite", {31'd0, memWrite}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("partial_store_mem", mw(8'h30), 32'hAA22_3344);

        chk("pending_expectations", exp_q.size(), 32'd0);
        chk("strobe_spacing_violations", viol, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_master.md
Name: data_mem_master

Overview:
- Initiator for the byte-wide data memory.
- Turns one word, halfword or byte load/store request from the CPU datapath into a sequence of single-byte accesses on the memory's write / address / data-in / data-out interface.
- Handles byte sequencing, little-endian assembly and write-strobe spacing, so the datapath sees a single request/done handshake.

Parameters:
- dataWidth, 8, memory data width (one byte per location).
- addressWidth, 32, byte address width on both sides.
- wordBytes, 4, bytes per CPU word. CPU data width = dataWidth*wordBytes. Only 4 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  1  start request; sampled only in IDLE
- we  input  1  1 = store, 0 = load; sampled with req
- size  input  2  0 = byte, 1 = halfword, 2 or 3 = word; sampled with req
- addr  input  addressWidth  base byte address; sampled with req
- wdata  input  dataWidth*wordBytes  store data; sampled with req
- rdata  output  dataWidth*wordBytes  load result, zero-extended; valid while done=1, held until next load completes
- busy  output  1  high from the cycle after req acceptance through the done cycle
- done  output  1  one-cycle completion pulse
- memWrite  output  1  memory write strobe
- memAddress  output  addressWidth  memory address bus
- memDataOut  output  dataWidth  byte to memory data-in
- memDataIn  input  dataWidth  byte from memory data-out (combinational read)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- All outputs are registered.
- Reset values: busy=0, done=0, memWrite=0, memAddress=0, memDataOut=0, rdata=0. State goes to IDLE, byte index to 0.
- Byte count n = 1, 2 or 4 from size. Byte i is accessed at addr+i (mod 2^addressWidth; wrap allowed, no alignment check).
- Byte order is little-endian: byte i maps to data bits [8i+7:8i].
- Request capture: req=1 in IDLE latches we, size, addr and wdata. req while busy is ignored; it is not queued.
- FSM states: IDLE, RD, WR_SETUP, WR_STROBE, DONE.
- IDLE:
  - req & !we -> RD, i=0.
  - req & we -> WR_SETUP, i=0.
- RD:
  - Drive memAddress=addr+i with memWrite=0.
  - At the clock edge, capture memDataIn into byte i of the result.
  - Go to RD with i+1 if i<n-1, else DONE.
- WR_SETUP:
  - Drive memAddress=addr+i and memDataOut=wdata byte i with memWrite=0.
  - Always goes to WR_STROBE.
- WR_STROBE:
  - Hold the same address and data with memWrite=1.
  - Go to WR_SETUP with i+1 if i<n-1, else DONE.
- Write spacing: memWrite must return low for at least one cycle between byte writes. Address and data change only while memWrite=0, because the memory writes level-sensitively on strobe/data changes.
- DONE:
  - done=1 and memWrite=0.
  - For loads, rdata = assembled bytes, upper unused bytes 0.
  - Always goes to IDLE.
  - A req seen in DONE is ignored; the earliest next acceptance is the following IDLE cycle.
- Latency (req cycle = T): done is asserted in cycle T+n+1 for loads and T+2n+1 for stores. Word load = 5 cycles, word store = 9 cycles.
- Reset mid-operation: the next edge forces IDLE with memWrite=0. Bytes already strobed stay written (partial store is allowed). No done pulse is produced.
- For a store, rdata keeps its previous value.

Decomposition:
- Shared package holds:
  - FSM state encoding constants.
  - Size codes (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2).
  - A function mapping size to byte count.
- No sub-module. A single FSM plus datapath registers is the natural split.

Test Plan:
- Word load: memory holds 11,22,33,44 at 0x10..0x13; req, we=0, size=2, addr=0x10 -> done in cycle T+5, rdata=0x44332211, memWrite stays 0 throughout.
- Word store: wdata=0xDEADBEEF to addr 0x20 -> memWrite pulses exactly 4 times, each preceded by a low cycle; memory 0x20..0x23 = EF,BE,AD,DE; done at T+9.
- Halfword/byte: halfword load from 0x21 returns 0x0000ADBE. Byte store 0x5A at 0x22 changes only 0x22; 0x21 and 0x23 are unchanged.
- Wrap: word load at addr 0xFFFFFFFE accesses FFFFFFFE, FFFFFFFF, 0, 1 in that order.
- Busy interlock: req held high across a word load -> exactly one access sequence per IDLE acceptance; the second request starts no earlier than T+6.
- Reset mid-store: assert rst during the third WR_STROBE -> next cycle memWrite=0, busy=0, done never pulses; bytes 0-2 are written and byte 3 is unchanged.
